pb_event_gen: RTL and testbench

//  Consumer side of the push-button path: takes the debounced level from pbdebounce.

---
 rtl/pb_event_gen.sv | 166 ++++++++++++++++
 tb/tb_pb_event_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pb_event_gen.sv
// ============================================================================
//  Module   : pb_event_gen
//  Purpose  : Turns a debounced push-button level into single-cycle press,
//             release, step (with auto-repeat) and long-press events.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pb_event_gen #(
  parameter int TICK_DIV     = 50000,
  parameter int LONG_MS      = 1000,
  parameter int REP_DELAY_MS = 500,
  parameter int REP_RATE_MS  = 100,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pb_level_i,
  input  logic             en_i,
  output logic             press_p_o,
  output logic             release_p_o,
  output logic             step_p_o,
  output logic             long_p_o,
  output logic             held_o,
  output logic [CNT_W-1:0] hold_ms_o
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int RC_W = (REP_RATE_MS > 1) ? $clog2(REP_RATE_MS + 1) : 1;

  localparam logic [PW-1:0]    c_tick_last = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] c_hold_max  = '1;
  localparam logic [CNT_W-1:0] c_long      = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0] c_rep_delay = CNT_W'(REP_DELAY_MS);
  localparam logic [RC_W-1:0]  c_rep_rate  = RC_W'(REP_RATE_MS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic             s1_q, s2_q, s3_q;
  logic [1:0]       vld_q;
  logic             armed_q;
  logic [PW-1:0]    presc_q;
  state_t           state_q;
  logic [CNT_W-1:0] hold_q;
  logic [RC_W-1:0]  rc_q;
  logic             long_done_q;
  logic             press_q, release_q, step_q, long_q, held_q;

  logic             rise_w, fall_w, tick_w, accept_w;
  logic [CNT_W-1:0] hold_d;
  logic [RC_W-1:0]  rc_d;
  logic [PW-1:0]    presc_d;

  assign rise_w   = s2_q & ~s3_q;
  assign fall_w   = ~s2_q & s3_q;
  assign tick_w   = (presc_q == c_tick_last);
  assign accept_w = (state_q == IDLE) & rise_w & armed_q & en_i;
  assign hold_d   = (hold_q == c_hold_max) ? hold_q : hold_q + 1'b1;
  assign rc_d     = rc_q + 1'b1;
  assign presc_d  = (accept_w || tick_w) ? '0 : presc_q + 1'b1;

  // vld_q marks s2 as a real sample of the pin, so the reset value of the
  // synchronizer cannot arm the detector while the button is held through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      presc_q <= '0;
    end else begin
      s1_q    <= pb_level_i;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      vld_q   <= {vld_q[0], 1'b1};
      presc_q <= presc_d;
      if (!en_i)
        armed_q <= 1'b0;
      else if (vld_q[1] && !s2_q)
        armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      rc_q        <= '0;
      long_done_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      step_q      <= 1'b0;
      long_q      <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      step_q    <= 1'b0;
      long_q    <= 1'b0;
      if (!en_i) begin
        state_q     <= IDLE;
        held_q      <= 1'b0;
        long_done_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            long_done_q <= 1'b0;
            if (accept_w) begin
              press_q <= 1'b1;
              step_q  <= 1'b1;
              hold_q  <= '0;
              rc_q    <= '0;
              held_q  <= 1'b1;
              state_q <= HOLD;
            end
          end
          HOLD, REPEAT: begin
            // A fall outranks a coincident tick: nothing but release_p.
            if (fall_w) begin
              release_q <= 1'b1;
              held_q    <= 1'b0;
              state_q   <= IDLE;
            end else if (tick_w) begin
              hold_q <= hold_d;
              if (!long_done_q && hold_d == c_long) begin
                long_q      <= 1'b1;
                long_done_q <= 1'b1;
              end
              if (state_q == HOLD) begin
                if (hold_d == c_rep_delay) begin
                  step_q  <= 1'b1;
                  rc_q    <= '0;
                  state_q <= REPEAT;
                end
              end else if (rc_d == c_rep_rate) begin
                step_q <= 1'b1;
                rc_q   <= '0;
              end else begin
                rc_q <= rc_d;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign press_p_o   = press_q;
  assign release_p_o = release_q;
  assign step_p_o    = step_q;
  assign long_p_o    = long_q;
  assign held_o      = held_q;
  assign hold_ms_o   = hold_q;

endmodule

`default_nettype wire

// File: tb/tb_pb_event_gen.sv
// ============================================================================
//  Module   : tb_pb_event_gen
//  Purpose  : Directed self-checking bench for pb_event_gen.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pb_event_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pb_level_i;
  logic       en_i;
  logic       press_p_o, release_p_o, step_p_o, long_p_o, held_o;
  logic [7:0] hold_ms_o;

  pb_event_gen #(
    .TICK_DIV    (4),
    .LONG_MS     (8),
    .REP_DELAY_MS(5),
    .REP_RATE_MS (2),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pb_level_i (pb_level_i),
    .en_i       (en_i),
    .press_p_o  (press_p_o),
    .release_p_o(release_p_o),
    .step_p_o   (step_p_o),
    .long_p_o   (long_p_o),
    .held_o     (held_o),
    .hold_ms_o  (hold_ms_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pb;
    logic       en;
    logic [4:0] flags;  // {press, release, step, long, held}
    logic [7:0] hold;
  } vec_t;

  vec_t tbl[16];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_held = 0;
  int   q_press[$], q_rel[$], q_step[$], q_long[$];
  int   exp_steps[5] = '{0, 20, 28, 36, 44};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (press_p_o)   q_press.push_back(cyc);
    if (release_p_o) q_rel.push_back(cyc);
    if (step_p_o)    q_step.push_back(cyc);
    if (long_p_o)    q_long.push_back(cyc);
    if (held_o)      n_held = n_held + 1;
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int flags_now();
    return {27'd0, press_p_o, release_p_o, step_p_o, long_p_o, held_o};
  endfunction

  int bp, bs, br, bl, hb, p, c0;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 5'b00000, 8'd0};
    tbl[1]  = '{1'b1, 1'b1, 5'b00000, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 5'b10101, 8'd0};
    tbl[3]  = '{1'b1, 1'b1, 5'b00001, 8'd0};
    tbl[4]  = '{1'b1, 1'b1, 5'b00001, 8'd0};
    tbl[5]  = '{1'b1, 1'b1, 5'b00001, 8'd0};
    tbl[6]  = '{1'b1, 1'b1, 5'b00001, 8'd1};
    tbl[7]  = '{1'b1, 1'b1, 5'b00001, 8'd1};
    tbl[8]  = '{1'b1, 1'b1, 5'b00001, 8'd1};
    tbl[9]  = '{1'b1, 1'b1, 5'b00001, 8'd1};
    tbl[10] = '{1'b0, 1'b1, 5'b00001, 8'd2};
    tbl[11] = '{1'b0, 1'b1, 5'b00001, 8'd2};
    tbl[12] = '{1'b0, 1'b1, 5'b01000, 8'd2};
    tbl[13] = '{1'b0, 1'b1, 5'b00000, 8'd2};
    tbl[14] = '{1'b0, 1'b1, 5'b00000, 8'd2};
    tbl[15] = '{1'b0, 1'b1, 5'b00000, 8'd2};

    rst_n = 1'b0; pb_level_i = 1'b0; en_i = 1'b1;
    tick_n(3);
    chk("reset_flags", flags_now(), 0);
    chk("reset_hold", int'(hold_ms_o), 0);
    rst_n = 1'b1;
    tick_n(5);

    // Short press, cycle by cycle
    for (int i = 0; i < 16; i++) begin
      pb_level_i = tbl[i].pb;
      en_i       = tbl[i].en;
      tick_n(1);
      chk($sformatf("short_flags[%0d]", i), flags_now(), int'(tbl[i].flags));
      chk($sformatf("short_hold[%0d]", i), int'(hold_ms_o), int'(tbl[i].hold));
    end

    // Long hold with auto-repeat and long-press
    bp = q_press.size(); bs = q_step.size(); br = q_rel.size();
    bl = q_long.size(); hb = n_held;
    pb_level_i = 1'b1; tick_n(50);
    pb_level_i = 1'b0; tick_n(8);
    chk("long_press_cnt", q_press.size() - bp, 1);
    p = (q_press.size() > bp) ? q_press[bp] : 0;
    chk("long_step_cnt", q_step.size() - bs, 5);
    for (int k = 0; k < 5; k++)
      if (bs + k < q_step.size())
        chk($sformatf("long_step_ofs[%0d]", k), q_step[bs+k] - p, exp_steps[k]);
    chk("long_longp_cnt", q_long.size() - bl, 1);
    if (q_long.size() > bl) chk("long_longp_ofs", q_long[bl] - p, 32);
    chk("long_rel_cnt", q_rel.size() - br, 1);
    if (q_rel.size() > br) chk("long_rel_ofs", q_rel[br] - p, 50);
    chk("long_held_cycles", n_held - hb, 50);
    chk("long_hold_ms", int'(hold_ms_o), 12);

    // Button held through reset
    rst_n = 1'b0; pb_level_i = 1'b1;
    tick_n(2);
    rst_n = 1'b1;
    bp = q_press.size();
    tick_n(12);
    chk("thru_rst_no_press", q_press.size() - bp, 0);
    pb_level_i = 1'b0; tick_n(5);
    bp = q_press.size(); br = q_rel.size(); c0 = cyc;
    pb_level_i = 1'b1; tick_n(6);
    chk("thru_rst_press_cnt", q_press.size() - bp, 1);
    if (q_press.size() > bp) chk("thru_rst_press_lat", q_press[bp] - c0, 3);
    pb_level_i = 1'b0; tick_n(6);
    chk("thru_rst_rel_cnt", q_rel.size() - br, 1);

    // Fall coincides with the 5th tick
    bp = q_press.size(); bs = q_step.size(); br = q_rel.size(); bl = q_long.size();
    pb_level_i = 1'b1; tick_n(20);
    pb_level_i = 1'b0; tick_n(8);
    p = (q_press.size() > bp) ? q_press[bp] : 0;
    chk("falltick_press_cnt", q_press.size() - bp, 1);
    chk("falltick_rel_cnt", q_rel.size() - br, 1);
    if (q_rel.size() > br) chk("falltick_rel_ofs", q_rel[br] - p, 20);
    chk("falltick_step_cnt", q_step.size() - bs, 1);
    chk("falltick_long_cnt", q_long.size() - bl, 0);
    chk("falltick_hold_ms", int'(hold_ms_o), 4);

    // en dropped mid-hold
    bp = q_press.size(); br = q_rel.size();
    pb_level_i = 1'b1; tick_n(15);
    chk("en_drop_held_before", int'(held_o), 1);
    en_i = 1'b0; tick_n(1);
    chk("en_drop_held_after", int'(held_o), 0);
    tick_n(4);
    en_i = 1'b1; tick_n(10);
    pb_level_i = 1'b0; tick_n(6);
    chk("en_drop_press_cnt", q_press.size() - bp, 1);
    chk("en_drop_rel_cnt", q_rel.size() - br, 0);
    chk("en_drop_hold_ms", int'(hold_ms_o), 3);

    // Reset in REPEAT
    bs = q_step.size();
    pb_level_i = 1'b1; tick_n(25);
    chk("rst_rep_held", int'(held_o), 1);
    chk("rst_rep_steps", q_step.size() - bs, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_rep_flags", flags_now(), 0);
    chk("rst_rep_hold", int'(hold_ms_o), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bp = q_press.size(); br = q_rel.size();
    tick_n(15);
    chk("rst_rep_no_press", q_press.size() - bp, 0);
    pb_level_i = 1'b0; tick_n(5);
    chk("rst_rep_no_rel", q_rel.size() - br, 0);
    pb_level_i = 1'b1; tick_n(5);
    chk("rst_rep_repress", q_press.size() - bp, 1);
    chk("rst_rep_repress_hold", int'(hold_ms_o), 0);
    pb_level_i = 1'b0; tick_n(6);
    chk("rst_rep_rel", q_rel.size() - br, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
